// File: rtl/alu_rs_scheduler.sv
// Reservation station for the single-cycle ALU: captures operands from two result buses and issues the lowest-index ready entry.
// Issue is registered (dispatch-ready -> alu_input two cycles later); rs_full stalls dispatch, rdy_in low freezes all state.
module alu_rs_scheduler #(
   parameter int RS_SIZE      = 8,
   parameter int RS_IDX_BIT   = 3,
   parameter int ROB_SIZE_BIT = 4,
   parameter int TYPE_BIT     = 5
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    rdy_in,
   input  logic                    rob_clear,
   input  logic                    disp_valid,
   input  logic [TYPE_BIT-1:0]     disp_type,
   input  logic [ROB_SIZE_BIT-1:0] disp_rob_id,
   input  logic                    disp_r1_rdy,
   input  logic [31:0]             disp_r1_val,
   input  logic [ROB_SIZE_BIT-1:0] disp_r1_dep,
   input  logic                    disp_r2_rdy,
   input  logic [31:0]             disp_r2_val,
   input  logic [ROB_SIZE_BIT-1:0] disp_r2_dep,
   input  logic                    cdb0_valid,
   input  logic [ROB_SIZE_BIT-1:0] cdb0_rob_id,
   input  logic [31:0]             cdb0_val,
   input  logic                    cdb1_valid,
   input  logic [ROB_SIZE_BIT-1:0] cdb1_rob_id,
   input  logic [31:0]             cdb1_val,
   output logic                    rs_full,
   output logic                    alu_input,
   output logic [TYPE_BIT-1:0]     arith_type,
   output logic [31:0]             r1_val,
   output logic [31:0]             r2_val,
   output logic [ROB_SIZE_BIT-1:0] inst_rob_id
);

   logic [RS_SIZE-1:0]      r_busy;
   logic [TYPE_BIT-1:0]     r_type   [RS_SIZE];
   logic [ROB_SIZE_BIT-1:0] r_rob    [RS_SIZE];
   logic [RS_SIZE-1:0]      r_r1_rdy;
   logic [RS_SIZE-1:0]      r_r2_rdy;
   logic [31:0]             r_r1_val [RS_SIZE];
   logic [31:0]             r_r2_val [RS_SIZE];
   logic [ROB_SIZE_BIT-1:0] r_r1_dep [RS_SIZE];
   logic [ROB_SIZE_BIT-1:0] r_r2_dep [RS_SIZE];

   logic                    r_alu_input;
   logic [TYPE_BIT-1:0]     r_arith_type;
   logic [31:0]             r_r1_out;
   logic [31:0]             r_r2_out;
   logic [ROB_SIZE_BIT-1:0] r_rob_out;

   logic [32:0]             w_snp1 [RS_SIZE];
   logic [32:0]             w_snp2 [RS_SIZE];
   logic [32:0]             w_dsnp1;
   logic [32:0]             w_dsnp2;
   logic [RS_IDX_BIT-1:0]   w_free_idx;
   logic [RS_IDX_BIT-1:0]   w_sel_idx;
   logic                    w_sel_vld;
   logic                    w_disp_ok;

   // {hit, value}; cdb0 has priority when both buses carry the same tag
   function automatic logic [32:0] snoop(input logic [ROB_SIZE_BIT-1:0] dep);
      if (cdb0_valid && dep == cdb0_rob_id) return {1'b1, cdb0_val};
      if (cdb1_valid && dep == cdb1_rob_id) return {1'b1, cdb1_val};
      return 33'd0;
   endfunction

   always_comb begin
      w_dsnp1    = snoop(disp_r1_dep);
      w_dsnp2    = snoop(disp_r2_dep);
      w_free_idx = '0;
      w_sel_idx  = '0;
      w_sel_vld  = 1'b0;
      for (int i = 0; i < RS_SIZE; i++) begin
         w_snp1[i] = snoop(r_r1_dep[i]);
         w_snp2[i] = snoop(r_r2_dep[i]);
      end
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (!r_busy[i]) w_free_idx = RS_IDX_BIT'(i);
         if (r_busy[i] && r_r1_rdy[i] && r_r2_rdy[i]) begin
            w_sel_vld = 1'b1;
            w_sel_idx = RS_IDX_BIT'(i);
         end
      end
   end

   assign rs_full   = &r_busy;
   assign w_disp_ok = disp_valid && !rs_full;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_busy       <= '0;
         r_r1_rdy     <= '0;
         r_r2_rdy     <= '0;
         r_alu_input  <= 1'b0;
         r_arith_type <= '0;
         r_r1_out     <= '0;
         r_r2_out     <= '0;
         r_rob_out    <= '0;
      end else if (rdy_in) begin
         if (rob_clear) begin
            r_busy       <= '0;
            r_alu_input  <= 1'b0;
            r_arith_type <= '0;
            r_r1_out     <= '0;
            r_r2_out     <= '0;
            r_rob_out    <= '0;
         end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
               if (r_busy[i] && !r_r1_rdy[i] && w_snp1[i][32]) begin
                  r_r1_rdy[i] <= 1'b1;
                  r_r1_val[i] <= w_snp1[i][31:0];
               end
               if (r_busy[i] && !r_r2_rdy[i] && w_snp2[i][32]) begin
                  r_r2_rdy[i] <= 1'b1;
                  r_r2_val[i] <= w_snp2[i][31:0];
               end
            end
            // Select uses pre-edge state, so this cycle's wakeups wait one cycle
            if (w_sel_vld) begin
               r_alu_input         <= 1'b1;
               r_arith_type        <= r_type[w_sel_idx];
               r_r1_out            <= r_r1_val[w_sel_idx];
               r_r2_out            <= r_r2_val[w_sel_idx];
               r_rob_out           <= r_rob[w_sel_idx];
               r_busy[w_sel_idx]   <= 1'b0;
            end else begin
               r_alu_input <= 1'b0;
            end
            if (w_disp_ok) begin
               r_busy[w_free_idx]   <= 1'b1;
               r_type[w_free_idx]   <= disp_type;
               r_rob[w_free_idx]    <= disp_rob_id;
               r_r1_rdy[w_free_idx] <= disp_r1_rdy | w_dsnp1[32];
               r_r1_val[w_free_idx] <= disp_r1_rdy ? disp_r1_val : w_dsnp1[31:0];
               r_r1_dep[w_free_idx] <= disp_r1_dep;
               r_r2_rdy[w_free_idx] <= disp_r2_rdy | w_dsnp2[32];
               r_r2_val[w_free_idx] <= disp_r2_rdy ? disp_r2_val : w_dsnp2[31:0];
               r_r2_dep[w_free_idx] <= disp_r2_dep;
            end
         end
      end
   end

   assign alu_input   = r_alu_input;
   assign arith_type  = r_arith_type;
   assign r1_val      = r_r1_out;
   assign r2_val      = r_r2_out;
   assign inst_rob_id = r_rob_out;

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Directed bench for alu_rs_scheduler: one vector per clock, outputs checked 1 time unit after the edge.
module tb_alu_rs_scheduler;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, rob_clear, disp_valid;
   logic [4:0]  disp_type;
   logic [3:0]  disp_rob_id, disp_r1_dep, disp_r2_dep;
   logic        disp_r1_rdy, disp_r2_rdy;
   logic [31:0] disp_r1_val, disp_r2_val;
   logic        cdb0_valid, cdb1_valid;
   logic [3:0]  cdb0_rob_id, cdb1_rob_id;
   logic [31:0] cdb0_val, cdb1_val;
   logic        rs_full, alu_input;
   logic [4:0]  arith_type;
   logic [31:0] r1_val, r2_val;
   logic [3:0]  inst_rob_id;

   int checks   = 0;
   int failures = 0;

   always #5 clk_in = ~clk_in;

   alu_rs_scheduler dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
      .disp_valid(disp_valid), .disp_type(disp_type), .disp_rob_id(disp_rob_id),
      .disp_r1_rdy(disp_r1_rdy), .disp_r1_val(disp_r1_val), .disp_r1_dep(disp_r1_dep),
      .disp_r2_rdy(disp_r2_rdy), .disp_r2_val(disp_r2_val), .disp_r2_dep(disp_r2_dep),
      .cdb0_valid(cdb0_valid), .cdb0_rob_id(cdb0_rob_id), .cdb0_val(cdb0_val),
      .cdb1_valid(cdb1_valid), .cdb1_rob_id(cdb1_rob_id), .cdb1_val(cdb1_val),
      .rs_full(rs_full), .alu_input(alu_input), .arith_type(arith_type),
      .r1_val(r1_val), .r2_val(r2_val), .inst_rob_id(inst_rob_id)
   );

   typedef struct {
      logic        rst, rdy, clr, dv;
      logic [4:0]  dtype;
      logic [3:0]  drob;
      logic        r1rdy;
      logic [31:0] r1val;
      logic [3:0]  r1dep;
      logic        r2rdy;
      logic [31:0] r2val;
      logic [3:0]  r2dep;
      logic        c0v;
      logic [3:0]  c0id;
      logic [31:0] c0val;
      logic        c1v;
      logic [3:0]  c1id;
      logic [31:0] c1val;
      logic        e_alu;
      logic [4:0]  e_type;
      logic [31:0] e_r1, e_r2;
      logic [3:0]  e_rob;
      logic        e_full;
   } vec_t;

   function automatic vec_t V();
      vec_t v;
      v = '{default: '0};
      v.rdy = 1'b1;
      return v;
   endfunction

   function automatic vec_t D(input vec_t b, input logic [4:0] t, input logic [3:0] rob,
                              input logic ar, input logic [31:0] av, input logic [3:0] ad,
                              input logic br, input logic [31:0] bv, input logic [3:0] bd);
      vec_t v = b;
      v.dv = 1'b1; v.dtype = t; v.drob = rob;
      v.r1rdy = ar; v.r1val = av; v.r1dep = ad;
      v.r2rdy = br; v.r2val = bv; v.r2dep = bd;
      return v;
   endfunction

   function automatic vec_t C0(input vec_t b, input logic [3:0] id, input logic [31:0] val);
      vec_t v = b;
      v.c0v = 1'b1; v.c0id = id; v.c0val = val;
      return v;
   endfunction

   function automatic vec_t C1(input vec_t b, input logic [3:0] id, input logic [31:0] val);
      vec_t v = b;
      v.c1v = 1'b1; v.c1id = id; v.c1val = val;
      return v;
   endfunction

   function automatic vec_t S(input vec_t b);
      vec_t v = b;
      v.rdy = 1'b0;
      return v;
   endfunction

   function automatic vec_t R(input vec_t b);
      vec_t v = b;
      v.rst = 1'b1;
      return v;
   endfunction

   function automatic vec_t CL(input vec_t b);
      vec_t v = b;
      v.clr = 1'b1;
      return v;
   endfunction

   function automatic vec_t E(input vec_t b, input logic a, input logic [4:0] t,
                              input logic [31:0] x, input logic [31:0] y,
                              input logic [3:0] rob, input logic f);
      vec_t v = b;
      v.e_alu = a; v.e_type = t; v.e_r1 = x; v.e_r2 = y; v.e_rob = rob; v.e_full = f;
      return v;
   endfunction

   task automatic apply(input string nm, input vec_t v);
      rst_in      = v.rst;   rdy_in      = v.rdy;   rob_clear   = v.clr;
      disp_valid  = v.dv;    disp_type   = v.dtype; disp_rob_id = v.drob;
      disp_r1_rdy = v.r1rdy; disp_r1_val = v.r1val; disp_r1_dep = v.r1dep;
      disp_r2_rdy = v.r2rdy; disp_r2_val = v.r2val; disp_r2_dep = v.r2dep;
      cdb0_valid  = v.c0v;   cdb0_rob_id = v.c0id;  cdb0_val    = v.c0val;
      cdb1_valid  = v.c1v;   cdb1_rob_id = v.c1id;  cdb1_val    = v.c1val;
      @(posedge clk_in);
      #1;
      checks++;
      if (alu_input !== v.e_alu || arith_type !== v.e_type || r1_val !== v.e_r1 ||
          r2_val !== v.e_r2 || inst_rob_id !== v.e_rob || rs_full !== v.e_full) begin
         failures++;
         $display("FAIL %s: got alu=%0d type=%h r1=%h r2=%h rob=%h full=%0d, expected alu=%0d type=%h r1=%h r2=%h rob=%h full=%0d",
                  nm, alu_input, arith_type, r1_val, r2_val, inst_rob_id, rs_full,
                  v.e_alu, v.e_type, v.e_r1, v.e_r2, v.e_rob, v.e_full);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time=%0t, required below 200000", $time);
      $fatal(1);
   end

   initial begin
      vec_t tbl[$];
      vec_t drop;

      // Basic issue, wakeup on each bus, dispatch bypass, bus priority
      tbl.push_back(E(R(V()), 0, 0, 0, 0, 0, 0));
      tbl.push_back(E(D(V(), 0, 3, 1, 5, 0, 1, 7, 0), 0, 0, 0, 0, 0, 0));
      tbl.push_back(E(V(), 1, 0, 5, 7, 3, 0));
      tbl.push_back(E(V(), 0, 0, 5, 7, 3, 0));
      tbl.push_back(E(D(V(), 1, 2, 0, 0, 1, 1, 4, 0), 0, 0, 5, 7, 3, 0));
      tbl.push_back(E(C0(V(), 1, 10), 0, 0, 5, 7, 3, 0));
      tbl.push_back(E(V(), 1, 1, 10, 4, 2, 0));
      tbl.push_back(E(V(), 0, 1, 10, 4, 2, 0));
      tbl.push_back(E(D(V(), 1, 5, 0, 0, 1, 1, 9, 0), 0, 1, 10, 4, 2, 0));
      tbl.push_back(E(C1(V(), 1, 32'h22), 0, 1, 10, 4, 2, 0));
      tbl.push_back(E(V(), 1, 1, 32'h22, 9, 5, 0));
      tbl.push_back(E(V(), 0, 1, 32'h22, 9, 5, 0));
      tbl.push_back(E(C1(D(V(), 5'h10, 7, 1, 3, 0, 0, 0, 6), 6, 32'hFFFF_FFFF), 0, 1, 32'h22, 9, 5, 0));
      tbl.push_back(E(V(), 1, 5'h10, 3, 32'hFFFF_FFFF, 7, 0));
      tbl.push_back(E(V(), 0, 5'h10, 3, 32'hFFFF_FFFF, 7, 0));
      tbl.push_back(E(C1(C0(D(V(), 3, 1, 0, 0, 2, 1, 1, 0), 2, 32'hAA), 2, 32'hBB), 0, 5'h10, 3, 32'hFFFF_FFFF, 7, 0));
      tbl.push_back(E(V(), 1, 3, 32'hAA, 1, 1, 0));
      tbl.push_back(E(V(), 0, 3, 32'hAA, 1, 1, 0));
      // rdy_in stalls: broadcasts ignored, stalled dispatch ignored, reset overrides stall
      tbl.push_back(E(D(V(), 2, 4, 1, 32'h11, 0, 0, 0, 9), 0, 3, 32'hAA, 1, 1, 0));
      tbl.push_back(E(S(C0(V(), 9, 32'h99)), 0, 3, 32'hAA, 1, 1, 0));
      tbl.push_back(E(S(C1(V(), 9, 32'h77)), 0, 3, 32'hAA, 1, 1, 0));
      tbl.push_back(E(S(C0(V(), 9, 32'h55)), 0, 3, 32'hAA, 1, 1, 0));
      tbl.push_back(E(V(), 0, 3, 32'hAA, 1, 1, 0));
      tbl.push_back(E(C0(V(), 9, 32'h44), 0, 3, 32'hAA, 1, 1, 0));
      tbl.push_back(E(V(), 1, 2, 32'h11, 32'h44, 4, 0));
      tbl.push_back(E(D(V(), 4, 6, 1, 1, 0, 1, 2, 0), 0, 2, 32'h11, 32'h44, 4, 0));
      tbl.push_back(E(S(C0(V(), 6, 32'h66)), 0, 2, 32'h11, 32'h44, 4, 0));
      tbl.push_back(E(S(V()), 0, 2, 32'h11, 32'h44, 4, 0));
      tbl.push_back(E(S(D(V(), 7, 8, 1, 32'hDEAD, 0, 1, 32'hBEEF, 0)), 0, 2, 32'h11, 32'h44, 4, 0));
      tbl.push_back(E(V(), 1, 4, 1, 2, 6, 0));
      tbl.push_back(E(V(), 0, 4, 1, 2, 6, 0));
      tbl.push_back(E(D(V(), 5, 10, 1, 8, 0, 1, 9, 0), 0, 4, 1, 2, 6, 0));
      tbl.push_back(E(S(V()), 0, 4, 1, 2, 6, 0));
      tbl.push_back(E(R(S(V())), 0, 0, 0, 0, 0, 0));
      tbl.push_back(E(V(), 0, 0, 0, 0, 0, 0));
      tbl.push_back(E(V(), 0, 0, 0, 0, 0, 0));

      for (int i = 0; i < tbl.size(); i++)
         apply($sformatf("vec%0d", i), tbl[i]);

      // Fill all entries with blocked ops; entry k waits on tag k
      for (int k = 0; k < 8; k++)
         apply($sformatf("fill%0d", k),
               E(D(V(), 5'(k), 4'(k + 8), 1'b0, 32'd0, 4'(k), 1'b1, 32'(100 + k), 4'd0),
                 1'b0, 5'd0, 32'd0, 32'd0, 4'd0, k == 7));
      drop = D(V(), 5'h1F, 15, 1, 1, 0, 1, 1, 0);
      apply("drop_when_full", E(drop, 0, 0, 0, 0, 0, 1));
      apply("wake_1_and_4", E(C1(C0(V(), 1, 32'h111), 4, 32'h444), 0, 0, 0, 0, 0, 1));
      apply("issue_entry1", E(V(), 1, 1, 32'h111, 101, 9, 0));
      apply("issue_entry4", E(V(), 1, 4, 32'h444, 104, 12, 0));
      apply("no_dropped_issue", E(V(), 0, 4, 32'h444, 104, 12, 0));

      // Flush with four busy entries while alu_input is high
      apply("wake_0_and_2", E(C1(C0(V(), 0, 5), 2, 32'h22), 0, 4, 32'h444, 104, 12, 0));
      apply("issue_entry0", E(V(), 1, 0, 5, 100, 8, 0));
      apply("issue_entry2", E(V(), 1, 2, 32'h22, 102, 10, 0));
      apply("clear", E(CL(drop), 0, 0, 0, 0, 0, 0));
      apply("post_clear_cdb", E(C1(C0(V(), 3, 1), 5, 2), 0, 0, 0, 0, 0, 0));
      apply("post_clear_idle0", E(C1(C0(V(), 6, 3), 7, 4), 0, 0, 0, 0, 0, 0));
      apply("post_clear_idle1", E(V(), 0, 0, 0, 0, 0, 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
